// File: rtl/codec_cfg_sequencer.sv
// Walks a programmable table of codec config words and issues one I2C write per entry.
// Handles NACK retry, transaction timeout and a settling gap. CFG_RETRY_STAT_EN adds retry_total_o.
module codec_cfg_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 10,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int IDX_W       = $clog2(NUM_REGS + 1)
) (
    input  logic              clk_i2c,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_cf_i,
    input  logic              tbl_we_i,
    input  logic [IDX_W-1:0]  tbl_addr_i,
    input  logic [DATA_W-1:0] tbl_data_i,
    input  logic              i2c_busy_i,
    input  logic              i2c_done_i,
    input  logic              i2c_nack_i,
    output logic              send_start_o,
    output logic [DATA_W-1:0] cf_data_o,
    output logic [IDX_W-1:0]  cf_idx_o,
    output logic              cf_busy_o,
    output logic              cf_done_o,
    output logic              cf_err_o,
    output logic [IDX_W-1:0]  cf_err_idx_o
`ifdef CFG_RETRY_STAT_EN
   ,output logic [7:0]        retry_total_o
`endif
);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam int TO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    logic [DATA_W-1:0] tbl [NUM_REGS];

    logic [2:0]        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [RTY_W-1:0]  retry, retry_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [IDX_W-1:0]  err_idx_q;
    logic              waiting, resolving, failed;
    logic              run_clr, err_set, go_gap;

    // Timeout is folded into the same resolve path as a NACK; a real done wins if both coincide.
    assign waiting   = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign resolving = waiting && (i2c_done_i || (to_cnt == TO_LAST));
    assign failed    = i2c_done_i ? i2c_nack_i : 1'b1;

    always_ff @(posedge clk_i2c) begin
        if (tbl_we_i && (state == S_IDLE) && (tbl_addr_i <= LAST_IDX))
            tbl[tbl_addr_i] <= tbl_data_i;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        retry_nxt = retry;
        gap_nxt   = gap_cnt;
        to_nxt    = to_cnt;
        run_clr   = 1'b0;
        err_set   = 1'b0;
        go_gap    = 1'b0;
        case (state)
            S_IDLE: if (start_cf_i && !i2c_busy_i) begin
                state_nxt = S_START;
                idx_nxt   = '0;
                retry_nxt = '0;
                run_clr   = 1'b1;
            end
            S_START: begin
                to_nxt    = '0;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                to_nxt = to_cnt + 1'b1;
                if ((state == S_WAIT_BUSY) && i2c_busy_i)
                    state_nxt = S_WAIT_DONE;
                if (resolving) begin
                    if (!failed) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = S_DONE;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            retry_nxt = '0;
                            go_gap    = 1'b1;
                        end
                    end else if (retry != RTY_MAX) begin
                        retry_nxt = retry + 1'b1;
                        go_gap    = 1'b1;
                    end else begin
                        state_nxt = S_ERROR;
                        err_set   = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = S_START;
                else                     gap_nxt   = gap_cnt + 1'b1;
            end
            S_DONE, S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (go_gap) begin
            gap_nxt   = '0;
            state_nxt = (GAP_CYC == 0) ? S_START : S_GAP;
        end
    end

    always_ff @(posedge clk_i2c or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            idx       <= '0;
            retry     <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (en_i) begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            retry   <= retry_nxt;
            gap_cnt <= gap_nxt;
            to_cnt  <= to_nxt;
            // Latch the word on entry to START so it is stable for the whole transaction.
            if ((state_nxt == S_START) && (state != S_START))
                data_q <= tbl[idx_nxt];
            if (run_clr) begin
                err_q     <= 1'b0;
                err_idx_q <= '0;
            end else if (err_set) begin
                err_q     <= 1'b1;
                err_idx_q <= idx;
            end
        end
    end

`ifdef CFG_RETRY_STAT_EN
    logic [7:0] retry_total;
    always_ff @(posedge clk_i2c or posedge rst_i) begin
        if (rst_i)
            retry_total <= '0;
        else if (en_i) begin
            if (run_clr)
                retry_total <= '0;
            else if (resolving && failed && (retry != RTY_MAX) && (retry_total != 8'hff))
                retry_total <= retry_total + 1'b1;
        end
    end
    assign retry_total_o = retry_total;
`endif

    assign send_start_o = (state == S_START);
    assign cf_busy_o    = (state != S_IDLE);
    assign cf_done_o    = (state == S_DONE) || (state == S_ERROR);
    assign cf_data_o    = data_q;
    assign cf_idx_o     = idx;
    assign cf_err_o     = err_q;
    assign cf_err_idx_o = err_idx_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: I2C master model plus a start-order scoreboard.
module tb_codec_cfg_sequencer;
    localparam int NUM_REGS = 10;
    localparam int GAP_CYC  = 8;
    localparam int TO_DELTA = 1 + 4096 + GAP_CYC;

    logic        clk = 1'b0;
    logic        rst, en, start_cf, tbl_we;
    logic [3:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        busy, done, nack;
    logic        send_start, cf_busy, cf_done, cf_err;
    logic [15:0] cf_data;
    logic [3:0]  cf_idx, cf_err_idx;
`ifdef CFG_RETRY_STAT_EN
    logic [7:0]  retry_total;
`endif

    codec_cfg_sequencer dut (
        .clk_i2c(clk), .rst_i(rst), .en_i(en), .start_cf_i(start_cf),
        .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .i2c_busy_i(busy), .i2c_done_i(done), .i2c_nack_i(nack),
        .send_start_o(send_start), .cf_data_o(cf_data), .cf_idx_o(cf_idx),
        .cf_busy_o(cf_busy), .cf_done_o(cf_done), .cf_err_o(cf_err),
        .cf_err_idx_o(cf_err_idx)
`ifdef CFG_RETRY_STAT_EN
       ,.retry_total_o(retry_total)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] gold [NUM_REGS] = '{16'h1e00, 16'h0c10, 16'h0e02, 16'h0a06, 16'h0805,
                                     16'h0017, 16'h0217, 16'h1001, 16'h1201, 16'h0c00};
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;
    int cmps = 0, errs = 0;
    int n_start = 0, n_done = 0, cyc = 0, last_start = 0, last_delta = 0;
    bit first_start = 1'b1;

    // I2C master model controls
    bit  silent = 1'b0, m_act = 1'b0;
    int  m_cnt = 0, nack_idx = 15, nack_times = 0, nack_used = 0;
    logic [3:0] m_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i);
        exp_q.push_back({8'(i), gold[i]});
    endtask

    // Scoreboard: every start pulse must match the next expected (idx, word).
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst && cf_done) n_done++;
        if (!cf_busy) first_start = 1'b1;
        if (send_start) begin
            n_start++;
            if (!first_start) begin
                last_delta = cyc - last_start;
                chk("start_spacing", 32'(last_delta >= GAP_CYC + 2), 32'd1);
            end
            first_start = 1'b0;
            last_start  = cyc;
            if (exp_q.size() == 0)
                chk("unexpected_start", 32'(cf_idx), 32'hffff_ffff);
            else begin
                mon_e = exp_q.pop_front();
                chk("start_idx", 32'(cf_idx), 32'(mon_e[23:16]));
                chk("start_data", 32'(cf_data), 32'(mon_e[15:0]));
            end
        end
    end

    // I2C master: busy from 2 cycles after start, done+nack 5 cycles after start.
    initial begin
        busy = 1'b0; done = 1'b0; nack = 1'b0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            nack = 1'b0;
            if (rst) begin
                m_act = 1'b0;
                busy  = 1'b0;
            end else if (m_act) begin
                m_cnt++;
                if (m_cnt == 2) busy = 1'b1;
                if (m_cnt == 5) begin
                    busy  = 1'b0;
                    done  = 1'b1;
                    m_act = 1'b0;
                    if (32'(m_idx) == nack_idx) begin
                        nack = (nack_used < nack_times);
                        nack_used++;
                    end
                end
            end else if (send_start && !silent) begin
                m_act = 1'b1;
                m_cnt = 0;
                m_idx = cf_idx;
            end
        end
    end

    task automatic run(input string tag, input int bound, input bit wr_busy);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 1'b0;
        start_cf = 1'b1;
        @(negedge clk);
        start_cf = 1'b0;
        chk({tag, "_err_clr"}, 32'(cf_err), 32'd0);
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            if (cf_done) seen = 1'b1;
            tbl_we = wr_busy && !seen;
        end
        tbl_we = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(cf_busy), 32'd0);
    endtask

    initial begin
        int s0;
        bit found;
        rst = 1'b1; en = 1'b1; start_cf = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(send_start), 32'd0);
        chk("rst_busy", 32'(cf_busy), 32'd0);
        chk("rst_done", 32'(cf_done), 32'd0);
        chk("rst_err", 32'(cf_err), 32'd0);
        chk("rst_err_idx", 32'(cf_err_idx), 32'd0);
        chk("rst_idx", 32'(cf_idx), 32'd0);
        chk("rst_data", 32'(cf_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            tbl_we = 1'b1; tbl_addr = 4'(i); tbl_data = gold[i];
            @(negedge clk);
        end
        tbl_we = 1'b0;

        // all ACK
        for (int i = 0; i < NUM_REGS; i++) push(i);
        s0 = n_start;
        run("ack", 1000, 1'b0);
        chk("ack_starts", 32'(n_start - s0), 32'd10);
        chk("ack_err", 32'(cf_err), 32'd0);

        // entry 3 NACKs twice
        nack_idx = 3; nack_times = 2; nack_used = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            push(i);
            if (i == 3) begin push(3); push(3); end
        end
        s0 = n_start;
        run("nack2", 1000, 1'b0);
        chk("nack2_starts", 32'(n_start - s0), 32'd12);
        chk("nack2_err", 32'(cf_err), 32'd0);
`ifdef CFG_RETRY_STAT_EN
        chk("nack2_retry_total", 32'(retry_total), 32'd2);
`endif

        // entry 5 always NACKs
        nack_idx = 5; nack_times = 1000; nack_used = 0;
        for (int i = 0; i < 5; i++) push(i);
        repeat (4) push(5);
        s0 = n_start;
        run("abort5", 1000, 1'b0);
        chk("abort5_starts", 32'(n_start - s0), 32'd9);
        chk("abort5_err", 32'(cf_err), 32'd1);
        chk("abort5_err_idx", 32'(cf_err_idx), 32'd5);
        nack_idx = 15;

        // master never responds: timeout on every attempt of entry 0
        silent = 1'b1;
        repeat (4) push(0);
        s0 = n_start;
        run("tmo", 4 * TO_DELTA + 200, 1'b0);
        chk("tmo_starts", 32'(n_start - s0), 32'd4);
        chk("tmo_spacing", 32'(last_delta), 32'(TO_DELTA));
        chk("tmo_err", 32'(cf_err), 32'd1);
        chk("tmo_err_idx", 32'(cf_err_idx), 32'd0);
        silent = 1'b0;

        // reset during WAIT_DONE of entry 4
        for (int i = 0; i < NUM_REGS; i++) push(i);
        start_cf = 1'b1;
        @(negedge clk);
        start_cf = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            #1;
            if (m_act && m_idx == 4'd4 && m_cnt == 3) found = 1'b1;
        end
        chk("rst_reach_e4", 32'(found), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_start", 32'(send_start), 32'd0);
        chk("mid_rst_busy", 32'(cf_busy), 32'd0);
        chk("mid_rst_idx", 32'(cf_idx), 32'd0);
        chk("mid_rst_data", 32'(cf_data), 32'd0);
        chk("mid_rst_err", 32'(cf_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = n_start;
        repeat (30) @(negedge clk);
        chk("post_rst_quiet", 32'(n_start - s0), 32'd0);
        for (int i = 0; i < NUM_REGS; i++) push(i);
        run("rerun", 1000, 1'b0);

        // writes while busy and to an out-of-range address are dropped
        tbl_addr = 4'd2; tbl_data = 16'hdead;
        for (int i = 0; i < NUM_REGS; i++) push(i);
        run("we_busy", 1000, 1'b1);
        tbl_we = 1'b1; tbl_addr = 4'd10; tbl_data = 16'hbeef;
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 4'd9; tbl_data = 16'h0c01;
        @(negedge clk);
        tbl_we = 1'b0;
        gold[9] = 16'h0c01;
        for (int i = 0; i < NUM_REGS; i++) push(i);
        run("readback", 1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Parametrised register-sequence configurator for an I2C-controlled audio codec.
- Holds a programmable table of NUM_REGS configuration words and issues one I2C write per entry through the existing I2C master handshake (start / busy / done).
- Adds behaviour the current codec setup path lacks: explicit NACK retry, transaction timeout, inter-write settling gap, and error reporting with the failing index.
- Sits between the top-level audio init control and the I2C master.

Parameters:
- DATA_W, 16: width of one configuration word (codec register address + data).
- NUM_REGS, 10: number of table entries written per sequence; legal range 1..255.
- MAX_RETRY, 3: retries per entry after a NACK or timeout before aborting.
- GAP_CYC, 8: idle cycles inserted after each acknowledged write, before the next start.
- TIMEOUT_CYC, 4096: maximum cycles waiting in WAIT_BUSY plus WAIT_DONE for one transaction.

Ports:
- clk_i2c  in  1  I2C-domain clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  clock enable; when 0, FSM and all counters hold.
- start_cf_i  in  1  level request to run the sequence.
- tbl_we_i  in  1  table write strobe.
- tbl_addr_i  in  IDX_W  table write address; IDX_W = $clog2(NUM_REGS+1).
- tbl_data_i  in  DATA_W  table write data.
- i2c_busy_i  in  1  I2C master busy.
- i2c_done_i  in  1  one-cycle transaction-complete pulse.
- i2c_nack_i  in  1  NACK flag; sampled only with i2c_done_i.
- send_start_o  out  1  one-cycle start pulse to the I2C master.
- cf_data_o  out  DATA_W  current configuration word.
- cf_idx_o  out  IDX_W  current entry index.
- cf_busy_o  out  1  sequence in progress.
- cf_done_o  out  1  one-cycle pulse when the sequence ends, whether successful or aborted.
- cf_err_o  out  1  sticky abort flag.
- cf_err_idx_o  out  IDX_W  index of the entry that exhausted its retries.

Behaviour:
- Reset: state=IDLE; all outputs 0; idx, retry count, gap counter and timeout counter cleared. Table contents are not altered by reset.
- Table writes:
  - Accepted on tbl_we_i only while cf_busy_o=0 and tbl_addr_i<NUM_REGS.
  - Otherwise ignored.
  - Write takes effect the next cycle.
- cf_data_o = table[idx] (registered), valid from START until the entry is resolved.
- IDLE: if start_cf_i && ~i2c_busy_i && en_i, go to START. Same cycle: idx=0, retry=0, cf_err_o=0, cf_err_idx_o=0.
- START:
  - send_start_o=1 for exactly this cycle; timeout counter cleared.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - i2c_busy_i=1 -> WAIT_DONE.
  - i2c_done_i -> RESOLVE.
- WAIT_DONE: i2c_done_i -> RESOLVE.
- Timeout: in WAIT_BUSY and WAIT_DONE the timeout counter increments each enabled cycle. Reaching TIMEOUT_CYC-1 is treated as a NACK.
- RESOLVE (evaluated combinationally in the done/timeout cycle):
  - ACK and idx==NUM_REGS-1 -> DONE.
  - ACK otherwise -> idx++, retry=0, go to GAP.
  - NACK/timeout with retry<MAX_RETRY -> retry++, go to GAP; idx unchanged.
  - NACK/timeout with retry==MAX_RETRY -> ERROR.
- GAP: counts GAP_CYC cycles, then START. GAP_CYC=0 goes directly to START.
- DONE: cf_done_o=1 for one cycle, then IDLE.
- ERROR: cf_err_o=1 (sticky until the next accepted start or reset); cf_err_idx_o=idx; cf_done_o=1 for one cycle; then IDLE.
- cf_busy_o=1 in every state except IDLE.
- start_cf_i held high after DONE re-runs the sequence; the rising edge is not required.
- i2c_done_i arriving in IDLE or GAP is ignored.
- Reset asserted mid-transaction returns to IDLE immediately; no further send_start_o is issued.
- en_i=0 in START: the send_start_o pulse is held until the enabled cycle, then dropped. The start is never issued twice.

Optional Feature:
- Macro CFG_RETRY_STAT_EN.
- Defined:
  - Adds output retry_total_o (8 bits): total retries in the current or most recent sequence.
  - Saturates at 255; cleared on accepted start and on reset.
- Undefined: port absent; no counter logic.

Test Plan:
- Defaults. Write 10 words (0x1e00, 0x0c10, ... 0x0c00); pulse start; model always ACKs -> exactly 10 send_start_o pulses, cf_data_o matching each entry in order, ≥8 idle cycles between writes, one cf_done_o, cf_err_o=0.
- NACK on entry 3 twice, then ACK -> 12 start pulses total; entry 3 issued 3 times; cf_err_o=0; retry_total_o=2 when enabled.
- Entry 5 always NACKs -> 4 attempts on idx 5; cf_err_o=1; cf_err_idx_o=5; cf_done_o pulse; no entry 6 issued.
- i2c_busy_i never asserts -> timeout after 4096 cycles per attempt; abort with cf_err_idx_o=0 after 4 attempts.
- rst_i asserted while in WAIT_DONE of entry 4 -> all outputs 0 next edge; table intact; rerun restarts at idx 0.
- tbl_we_i while busy, and write to address 10 -> both ignored; table readback via cf_data_o unchanged.
